// File: rtl/nvram_ioctl_bridge.sv
// Byte-serial bridge between the HPS ioctl channel and the game NVRAM buffer:
// serves upload reads, applies download writes, and requests a save when dirty.
module nvram_ioctl_bridge #(
  parameter int          ADDR_W   = 11,
  parameter logic [7:0]  NV_INDEX = 8'd4
) (
  input  logic              i_clk,
  input  logic              RESETn,
  input  logic              ioctl_upload,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic              ioctl_rd,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_dout,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              ioctl_upload_req,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_gnt,
  input  logic [7:0]        mem_rdata,
  input  logic              game_wr,
  input  logic              save_trig
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_REQ  = 2'd1;
  localparam logic [1:0] S_RD_DATA = 2'd2;
  localparam logic [1:0] S_WR_REQ  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [7:0]        din_q, din_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              dirty_q, dirty_d;
  logic              pend_q, pend_d;
  logic              upreq_q, upreq_d;
  logic              hit_up_q, hit_dn_q;

  logic hit_up, hit_dn, in_range, rd_go, wr_go, up_fall, dn_fall;

  assign hit_up   = ioctl_upload   && (ioctl_index == NV_INDEX);
  assign hit_dn   = ioctl_download && (ioctl_index == NV_INDEX);
  assign in_range = (ioctl_addr[24:ADDR_W] == '0);
  assign rd_go    = ioctl_rd && hit_up;
  assign wr_go    = ioctl_wr && hit_dn;
  assign up_fall  = hit_up_q && !hit_up;
  assign dn_fall  = hit_dn_q && !hit_dn;

  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (rd_go) begin
          if (in_range) begin
            addr_d  = ioctl_addr[ADDR_W-1:0];
            state_d = S_RD_REQ;
          end else begin
            din_d = 8'hFF;
          end
        end else if (wr_go && in_range) begin
          addr_d  = ioctl_addr[ADDR_W-1:0];
          wdata_d = ioctl_dout;
          state_d = S_WR_REQ;
        end
      end
      // A session dropping mid-request abandons the access.
      S_RD_REQ: begin
        if (!ioctl_upload)  state_d = S_IDLE;
        else if (mem_gnt)   state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        din_d   = mem_rdata;
        state_d = S_IDLE;
      end
      default: begin
        if (!ioctl_download || mem_gnt) state_d = S_IDLE;
      end
    endcase
  end

  // game_wr wins over a same-cycle clear so no modification is lost.
  assign dirty_d = game_wr || (dirty_q && !(up_fall || dn_fall));
  assign upreq_d = save_trig && dirty_q && !hit_up && !hit_dn && !pend_q;
  assign pend_d  = upreq_d || (pend_q && !up_fall);

  always_ff @(posedge i_clk or negedge RESETn) begin
    if (!RESETn) begin
      state_q  <= S_IDLE;
      din_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      dirty_q  <= 1'b0;
      pend_q   <= 1'b0;
      upreq_q  <= 1'b0;
      hit_up_q <= 1'b0;
      hit_dn_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      din_q    <= din_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      dirty_q  <= dirty_d;
      pend_q   <= pend_d;
      upreq_q  <= upreq_d;
      hit_up_q <= hit_up;
      hit_dn_q <= hit_dn;
    end
  end

  assign mem_req = ((state_q == S_RD_REQ) && ioctl_upload) ||
                   ((state_q == S_WR_REQ) && ioctl_download);
  assign mem_we  = (state_q == S_WR_REQ);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ioctl_din = din_q;
  assign ioctl_upload_req = upreq_q;
  assign ioctl_wait = (state_q != S_IDLE) || ((rd_go || wr_go) && in_range);

endmodule
